// File: rtl/pckthandler_pkg.sv
// Shared definitions for the CSI-2 style packet handler.
// Holds the FSM state encoding and the data-type codes decoded from the
// packet header DATA_ID field.
package pckthandler_pkg;

  typedef enum logic [1:0] {
    PH_DECODE = 2'd0,
    REC_DATA  = 2'd1,
    WAIT_EOT  = 2'd2
  } state_t;

  localparam logic [5:0] DT_SOF   = 6'h00;
  localparam logic [5:0] DT_EOF   = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

endpackage

// File: rtl/pckthandler_vc_if.sv
// Packet bus between the lane merger and the packet handler.
// Receive side: valid_stream, ph_select, ph_stream {WC, DATA_ID}, ecc_error,
// data_stream. Output side: out_stream, out_valid, out_be, out_last, out_vc,
// line_valid.
// master : the packet source / line consumer (drives the receive side).
// slave  : the packet handler (drives the output side).
interface pckthandler_vc_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  valid_stream;
  logic                  ph_select;
  logic [23:0]           ph_stream;
  logic                  ecc_error;
  logic [DATA_WIDTH-1:0] data_stream;

  logic [DATA_WIDTH-1:0] out_stream;
  logic                  out_valid;
  logic [NBYTES-1:0]     out_be;
  logic                  out_last;
  logic [1:0]            out_vc;
  logic                  line_valid;

  modport master (
    output valid_stream, ph_select, ph_stream, ecc_error, data_stream,
    input  out_stream, out_valid, out_be, out_last, out_vc, line_valid
  );

  modport slave (
    input  valid_stream, ph_select, ph_stream, ecc_error, data_stream,
    output out_stream, out_valid, out_be, out_last, out_vc, line_valid
  );
endinterface

// File: rtl/pckthandler_bytecnt.sv
// Remaining-byte counter for one long packet.
// Ports: rxbyteclkhs/reset_n clock and sync active-low reset; load/wc start
// a line with WC bytes; dec consumes one beat; be is the byte enable of the
// current beat; last flags that the current beat finishes the line.
module pckthandler_bytecnt #(
  parameter int NBYTES = 2
) (
  input  logic              rxbyteclkhs,
  input  logic              reset_n,
  input  logic              load,
  input  logic [15:0]       wc,
  input  logic              dec,
  output logic [NBYTES-1:0] be,
  output logic              last
);
  localparam logic [15:0] NB = 16'(NBYTES);

  logic [15:0] remaining;

  // Decrement by min(remaining, NBYTES): floors at zero on the last beat.
  function automatic logic [15:0] sub_sat(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'd0;
  endfunction

  // Byte i is enabled while more than i bytes remain, which gives all ones
  // for a full beat and the low `remaining` bits for the tail beat.
  always_comb begin
    be = '0;
    for (int i = 0; i < NBYTES; i++) be[i] = (remaining > 16'(i));
  end

  assign last = (remaining <= NB);

  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n)  remaining <= 16'd0;
    else if (load) remaining <= wc;
    else if (dec)  remaining <= sub_sat(remaining, NB);
  end
endmodule

// File: rtl/pckthandler_vc.sv
// Packet handler with per-virtual-channel frame tracking.
// Decodes each packet header (SOF/EOF/pixel/other), tracks frame_active per
// VC, and forwards pixel payload beats with one cycle of latency together
// with byte enables, last-beat flag and the line's VC.
// Ports: rxbyteclkhs clock, reset_n sync active-low reset, bus (slave side of
// the packet bus), frame_active per-VC frame state, err_ecc/err_frame/
// err_trunc/err_vc single-cycle error pulses.
module pckthandler_vc
  import pckthandler_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         NUM_VC     = 4,
  parameter logic [5:0] PIXEL_DT   = DT_RAW10
) (
  input  logic              rxbyteclkhs,
  input  logic              reset_n,
  pckthandler_vc_if.slave   bus,
  output logic [NUM_VC-1:0] frame_active,
  output logic              err_ecc,
  output logic              err_frame,
  output logic              err_trunc,
  output logic              err_vc
);
  localparam int NBYTES = DATA_WIDTH / 8;

  state_t                state;
  logic [NUM_VC-1:0]     fa_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;
  logic [NBYTES-1:0]     be_p1;
  logic                  last_p1;
  logic [1:0]            vc_p1;
  logic                  err_ecc_p1, err_frame_p1, err_trunc_p1, err_vc_p1;

  logic [1:0]        hdr_vc;
  logic [5:0]        hdr_dt;
  logic [15:0]       hdr_wc;
  logic              hdr_cyc, vc_ok, vc_act, pix_go, beat;
  logic [NUM_VC-1:0] vc_oh;
  logic [NBYTES-1:0] cnt_be;
  logic              cnt_last;

  assign hdr_dt  = bus.ph_stream[5:0];
  assign hdr_vc  = bus.ph_stream[7:6];
  assign hdr_wc  = bus.ph_stream[23:8];
  assign hdr_cyc = (state == PH_DECODE) && bus.valid_stream && bus.ph_select;
  assign vc_ok   = (32'(hdr_vc) < NUM_VC);

  // One-hot of the header VC, built by loop so no select can leave the
  // NUM_VC-wide frame vector.
  always_comb begin
    vc_oh = '0;
    for (int i = 0; i < NUM_VC; i++) vc_oh[i] = (hdr_vc == 2'(i));
  end
  assign vc_act = |(fa_p1 & vc_oh);

  assign pix_go = hdr_cyc && !bus.ecc_error && vc_ok && (hdr_dt == PIXEL_DT) &&
                  vc_act && (hdr_wc != 16'd0);
  assign beat   = (state == REC_DATA) && bus.valid_stream;

  pckthandler_bytecnt #(.NBYTES(NBYTES)) u_bytecnt (
    .rxbyteclkhs (rxbyteclkhs),
    .reset_n     (reset_n),
    .load        (pix_go),
    .wc          (hdr_wc),
    .dec         (beat),
    .be          (cnt_be),
    .last        (cnt_last)
  );

  // ---- stage p1: header decode / payload register ----
  always_ff @(posedge rxbyteclkhs) begin
    if (!reset_n) begin
      state        <= PH_DECODE;
      fa_p1        <= '0;
      data_p1      <= '0;
      vld_p1       <= 1'b0;
      be_p1        <= '0;
      last_p1      <= 1'b0;
      vc_p1        <= 2'd0;
      err_ecc_p1   <= 1'b0;
      err_frame_p1 <= 1'b0;
      err_trunc_p1 <= 1'b0;
      err_vc_p1    <= 1'b0;
    end else begin
      vld_p1       <= 1'b0;
      be_p1        <= '0;
      last_p1      <= 1'b0;
      err_ecc_p1   <= 1'b0;
      err_frame_p1 <= 1'b0;
      err_trunc_p1 <= 1'b0;
      err_vc_p1    <= 1'b0;
      case (state)
        PH_DECODE: begin
          if (hdr_cyc) begin
            state <= WAIT_EOT;
            if (bus.ecc_error) begin
              err_ecc_p1 <= 1'b1;
            end else if (!vc_ok) begin
              err_vc_p1 <= 1'b1;
            end else if (hdr_dt == DT_SOF) begin
              err_frame_p1 <= vc_act;
              fa_p1        <= fa_p1 | vc_oh;
            end else if (hdr_dt == DT_EOF) begin
              err_frame_p1 <= !vc_act;
              fa_p1        <= fa_p1 & ~vc_oh;
            end else if (hdr_dt == PIXEL_DT) begin
              if (!vc_act) begin
                err_frame_p1 <= 1'b1;
              end else if (pix_go) begin
                vc_p1 <= hdr_vc;
                state <= REC_DATA;
              end
            end
          end
        end
        REC_DATA: begin
          if (bus.valid_stream) begin
            data_p1 <= bus.data_stream;
            vld_p1  <= 1'b1;
            be_p1   <= cnt_be;
            last_p1 <= cnt_last;
            if (cnt_last) state <= WAIT_EOT;
          end else begin
            // Packet ended early: abandon the line and look for a header.
            err_trunc_p1 <= 1'b1;
            state        <= PH_DECODE;
          end
        end
        WAIT_EOT: begin
          if (!bus.valid_stream) state <= PH_DECODE;
        end
        default: state <= PH_DECODE;
      endcase
    end
  end

  assign bus.out_stream = data_p1;
  assign bus.out_valid  = vld_p1;
  assign bus.out_be     = be_p1;
  assign bus.out_last   = last_p1;
  assign bus.out_vc     = vc_p1;
  // Beats of a line are contiguous, so the line window is exactly the beats.
  assign bus.line_valid = vld_p1;
  assign frame_active   = fa_p1;
  assign err_ecc        = err_ecc_p1;
  assign err_frame      = err_frame_p1;
  assign err_trunc      = err_trunc_p1;
  assign err_vc         = err_vc_p1;
endmodule

// File: doc/pckthandler_vc.md
PCKTHANDLER_VC -- requirements
Module: pckthandler_vc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload bits per cycle; legal values 8/16/32; NBYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter NUM_VC, default 4, number of virtual channels tracked (1..4).
REQ-003 SHALL have parameter PIXEL_DT, default 6'h2B (RAW10), the data type accepted as pixel payload.
REQ-004 SHALL have one clock and a synchronous active-low reset: rxbyteclkhs  in  1  byte clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 valid_stream  in  1  high for the whole packet, low between packets (EOT).
REQ-007 ph_select  in  1  high on the header cycle only.
REQ-008 ph_stream  in  24  {WC_MSB, WC_LSB, DATA_ID}; VC = [7:6], DT = [5:0], WC = [23:8].
REQ-009 ecc_error  in  1  header ECC uncorrectable; qualified by the header cycle.
REQ-010 data_stream  in  DATA_WIDTH  payload bytes, byte 0 in [7:0].
REQ-011 out_stream  out  DATA_WIDTH  registered payload.
REQ-012 out_valid  out  1  out_stream beat valid.
REQ-013 out_be  out  NBYTES  per-byte enable of the beat.
REQ-014 out_last  out  1  final beat of a line.
REQ-015 out_vc  out  2  VC of the current line.
REQ-016 frame_active  out  NUM_VC  per-VC frame-in-progress.
REQ-017 line_valid  out  1  high from first to last beat of an accepted line.
REQ-018 err_ecc, err_frame, err_trunc, err_vc  out  1 each  single-cycle error pulses.

Function
REQ-019 SHALL implement states PH_DECODE, REC_DATA, WAIT_EOT.
REQ-020 Header cycle = PH_DECODE & valid_stream & ph_select; payload cycles with ph_select=0 in PH_DECODE are ignored.
REQ-021 Header with ecc_error: pulse err_ecc, go to WAIT_EOT; no other field is decoded (highest priority).
REQ-022 Header with VC >= NUM_VC: pulse err_vc, go to WAIT_EOT.
REQ-023 DT 6'h00 (SOF): set frame_active[VC]; if already set, pulse err_frame; go to WAIT_EOT.
REQ-024 DT 6'h01 (EOF): clear frame_active[VC]; if already clear, pulse err_frame; go to WAIT_EOT.
REQ-025 DT == PIXEL_DT, frame_active[VC]=1, WC != 0: load 16-bit remaining = WC, latch out_vc, go to REC_DATA.
REQ-026 DT == PIXEL_DT with frame_active[VC]=0: pulse err_frame, go to WAIT_EOT; WC=0: go to WAIT_EOT silently.
REQ-027 Any other DT: go to WAIT_EOT, no outputs.
REQ-028 REC_DATA, valid_stream=1: register data_stream to out_stream with out_valid=1 one cycle later (latency 1).
REQ-029 out_be = all ones if remaining >= NBYTES, else the low `remaining` bits set; remaining decrements by min(remaining, NBYTES).
REQ-030 Beat with remaining <= NBYTES: out_last=1 on that beat, go to WAIT_EOT; bytes beyond WC are never enabled.
REQ-031 REC_DATA, valid_stream=0 before the last beat: pulse err_trunc, drop line_valid, go to PH_DECODE, no out_last.
REQ-032 line_valid SHALL equal 1 on every out_valid beat of the line and 0 otherwise.
REQ-033 WAIT_EOT: go to PH_DECODE on the first cycle with valid_stream=0.
REQ-034 frame_active bits for different VCs SHALL be independent; a line on one VC never alters another.

Reset
REQ-035 reset_n=0 at a clock edge SHALL force PH_DECODE, clear frame_active, out_valid, out_be, out_last, line_valid, out_vc, all err_* and remaining; out_stream is cleared to 0.
REQ-036 Reset SHALL win over every simultaneous event, including mid-line; no out_last or error is emitted for the aborted line.

Structure
REQ-037 Package pckthandler_pkg SHALL hold the state encodings and DT constants (DT_SOF 6'h00, DT_EOF 6'h01, DT_RAW10 6'h2B).
REQ-038 Sub-module pckthandler_bytecnt SHALL hold the remaining counter, out_be generation and last-beat detect.

Verification
REQ-039 DATA_WIDTH=16: SOF VC0, pixel header WC=6, 3 beats -> 3 out_valid beats, out_be 2'b11 each, out_last on beat 3, frame_active[0]=1.
REQ-040 DATA_WIDTH=32, WC=5 -> beats out_be 4'hF then 4'h1 with out_last; EOF VC0 -> frame_active[0]=0.
REQ-041 Header with ecc_error=1 and DT=PIXEL_DT -> err_ecc pulse, no out_valid until the next valid packet.
REQ-042 Pixel header on VC2 with only VC0 active -> err_frame pulse, no beats; SOF VC2 then pixel -> beats with out_vc=2.
REQ-043 WC=8, DATA_WIDTH=16, valid_stream drops after 2 beats -> err_trunc pulse, line_valid=0, next header decoded.
REQ-044 reset_n=0 during beat 2 of a line -> all outputs 0 next cycle, frame_active=0, PH_DECODE.
